// File: rtl/ysyx_23060025_lsu.sv
// Load/store unit: takes one EXU request at a time, issues a single-cycle
// SRAM read or write strobe, and returns an extended load result or an
// error flag to the WBU with a valid/ready handshake.
module ysyx_23060025_lsu #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                mem_ren_i,
    input  logic                mem_wen_i,
    input  logic [2:0]          funct3_i,
    input  logic [ADDR_LEN-1:0] addr_i,
    input  logic [DATA_LEN-1:0] wdata_i,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_LEN-1:0] rdata_o,
    output logic                err_o,
    output logic                sram_ren,
    output logic [ADDR_LEN-1:0] sram_raddr,
    output logic                sram_wen,
    output logic [ADDR_LEN-1:0] sram_waddr,
    output logic [DATA_LEN-1:0] sram_wdata,
    output logic [7:0]          sram_wmask,
    input  logic [DATA_LEN-1:0] sram_rdata
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

    state_t              state, state_nx;
    logic [2:0]          f3_q;
    logic [1:0]          off_q;
    logic                accept, is_load, is_store;
    logic                f3_legal, misalign, req_err;
    logic                do_rd, do_wr;
    logic [3:0]          wmask_base;
    logic [7:0]          ld_byte;
    logic [15:0]         ld_half;
    logic [DATA_LEN-1:0] ld_ext;

    // in_ready folds in rstn so nothing is accepted while reset is held
    assign in_ready  = rstn & (state == IDLE);
    assign out_valid = (state == RESP);
    assign accept    = in_valid & in_ready;
    // a request flagged as both load and store is handled as a store
    assign is_store  = mem_wen_i;
    assign is_load   = mem_ren_i & ~mem_wen_i;

    // decode access size, legality and alignment of the incoming request
    always_comb begin
        f3_legal   = 1'b0;
        misalign   = 1'b0;
        wmask_base = 4'b0000;
        case (funct3_i)
            3'b000: begin f3_legal = 1'b1;      wmask_base = 4'b0001; end
            3'b001: begin f3_legal = 1'b1;      wmask_base = 4'b0011; misalign = addr_i[0]; end
            3'b010: begin f3_legal = 1'b1;      wmask_base = 4'b1111; misalign = |addr_i[1:0]; end
            3'b100: begin f3_legal = ~is_store; wmask_base = 4'b0001; end
            3'b101: begin f3_legal = ~is_store; wmask_base = 4'b0011; misalign = addr_i[0]; end
            default: f3_legal = 1'b0;
        endcase
    end

    // requests with no memory operation never raise an error
    assign req_err = (is_load | is_store) & (~f3_legal | misalign);
    assign do_rd   = accept & is_load  & ~req_err;
    assign do_wr   = accept & is_store & ~req_err;

    // SRAM strobes live only in the accept cycle; buses are zero otherwise
    assign sram_ren   = do_rd;
    assign sram_raddr = do_rd ? {addr_i[ADDR_LEN-1:2], 2'b00} : '0;
    assign sram_wen   = do_wr;
    assign sram_waddr = do_wr ? {addr_i[ADDR_LEN-1:2], 2'b00} : '0;
    assign sram_wdata = do_wr ? (wdata_i << {addr_i[1:0], 3'b000}) : '0;
    assign sram_wmask = do_wr ? {4'b0000, wmask_base << addr_i[1:0]} : 8'h00;

    // pick the addressed lane of the returned word and extend it
    always_comb begin
        ld_byte = sram_rdata[{off_q, 3'b000} +: 8];
        ld_half = sram_rdata[{off_q[1], 4'b0000} +: 16];
        case (f3_q)
            3'b000:  ld_ext = {{(DATA_LEN-8){ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {{(DATA_LEN-8){1'b0}}, ld_byte};
            3'b001:  ld_ext = {{(DATA_LEN-16){ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {{(DATA_LEN-16){1'b0}}, ld_half};
            default: ld_ext = sram_rdata;
        endcase
    end

    // next state: loads wait one cycle for SRAM data, everything else responds at once
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = do_rd ? RD_WAIT : RESP;
            RD_WAIT: state_nx = RESP;
            RESP:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // state register; reset abandons any in-flight access
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    // request capture and response data; held untouched through RESP
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
            rdata_o <= '0;
            err_o   <= 1'b0;
        end else if (accept) begin
            f3_q    <= funct3_i;
            off_q   <= addr_i[1:0];
            rdata_o <= '0;
            err_o   <= req_err;
        end else if (state == RD_WAIT) begin
            rdata_o <= ld_ext;
        end
    end

endmodule

// File: tb/tb_ysyx_23060025_lsu.sv
// Randomized bench for the LSU: a byte-array memory model predicts every
// load result, store strobe and error flag from the RV32I access rules.
module tb_ysyx_23060025_lsu;

    logic        clk, rstn;
    logic        in_valid, in_ready, mem_ren_i, mem_wen_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic        out_valid, out_ready, err_o;
    logic [31:0] rdata_o;
    logic        sram_ren, sram_wen;
    logic [31:0] sram_raddr, sram_waddr, sram_wdata, sram_rdata;
    logic [7:0]  sram_wmask;

    int errors = 0;
    int checks = 0;

    logic [31:0] sram_mem [16];
    logic [7:0]  ref_mem  [64];

    ysyx_23060025_lsu #(.ADDR_LEN(32), .DATA_LEN(32)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready),
        .mem_ren_i(mem_ren_i), .mem_wen_i(mem_wen_i),
        .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .rdata_o(rdata_o), .err_o(err_o),
        .sram_ren(sram_ren), .sram_raddr(sram_raddr),
        .sram_wen(sram_wen), .sram_waddr(sram_waddr),
        .sram_wdata(sram_wdata), .sram_wmask(sram_wmask),
        .sram_rdata(sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous SRAM: read data appears the cycle after the strobe
    always @(posedge clk) begin
        if (sram_ren) sram_rdata <= sram_mem[sram_raddr[5:2]];
        if (sram_wen)
            for (int b = 0; b < 4; b++)
                if (sram_wmask[b]) sram_mem[sram_waddr[5:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_word(input int idx, input logic [31:0] v);
        sram_mem[idx] = v;
        for (int b = 0; b < 4; b++) ref_mem[4*idx + b] = v[8*b +: 8];
    endtask

    // one complete transaction, checked against the reference model
    task automatic do_req(input logic ren, input logic wen, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input int stall);
        bit ld, st, legal, err, sgn;
        int size, off, lat;
        logic [31:0] exp_rd, exp_mask, hold;
        ld  = ren && !wen;
        st  = wen;
        sgn = (f3[2] == 1'b0);
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        off = addr % 4;
        err = (ld || st) && (!legal || (addr % size) != 0);
        exp_rd = 0;
        if (ld && !err) begin
            for (int b = 0; b < size; b++) exp_rd += ref_mem[(addr % 64) + b] << (8*b);
            if (sgn && size < 4 && exp_rd[8*size-1]) exp_rd = exp_rd | ~((32'd1 << (8*size)) - 1);
        end
        exp_mask = (st && !err) ? (((1 << size) - 1) << off) : 0;

        @(negedge clk);
        in_valid = 1; mem_ren_i = ren; mem_wen_i = wen;
        funct3_i = f3; addr_i = addr; wdata_i = wd; out_ready = 0;
        #1;
        chk("in_ready_idle", in_ready, 1);
        chk("sram_ren", sram_ren, ld && !err);
        chk("sram_raddr", sram_raddr, (ld && !err) ? (addr & ~32'd3) : 0);
        chk("sram_wen", sram_wen, st && !err);
        chk("sram_waddr", sram_waddr, (st && !err) ? (addr & ~32'd3) : 0);
        chk("sram_wdata", sram_wdata, (st && !err) ? (wd << (8*off)) : 0);
        chk("sram_wmask", sram_wmask, exp_mask);
        if (st && !err)
            for (int b = 0; b < size; b++) ref_mem[(addr % 64) + b] = wd[8*b +: 8];
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 0;
            lat++;
            if (!out_valid) begin
                chk("no_strobe_ren", sram_ren, 0);
                chk("no_strobe_wen", sram_wen, 0);
                chk("busy_in_ready", in_ready, 0);
            end
        end while (!out_valid && lat < 8);
        chk("latency", lat, (ld && !err) ? 2 : 1);
        chk("rdata", rdata_o, exp_rd);
        chk("err", err_o, err);
        hold = rdata_o;
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            chk("stall_valid", out_valid, 1);
            chk("stall_rdata", rdata_o, hold);
            chk("stall_in_ready", in_ready, 0);
        end
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk("done_valid", out_valid, 0);
        chk("done_in_ready", in_ready, 1);
    endtask

    initial begin
        rstn = 0; in_valid = 0; mem_ren_i = 0; mem_wen_i = 0;
        funct3_i = 0; addr_i = 0; wdata_i = 0; out_ready = 0;
        sram_rdata = 0;
        for (int i = 0; i < 16; i++) set_word(i, $urandom);
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_err", err_o, 0);
        in_valid = 1; mem_ren_i = 1; #1;
        chk("rst_sram_ren", sram_ren, 0);
        in_valid = 0; mem_ren_i = 0;
        @(negedge clk); rstn = 1; #1;
        chk("post_rst_in_ready", in_ready, 1);

        // directed cases
        set_word(0, 32'h80FF1234);
        do_req(1, 0, 3'b000, 32'h80000003, 0, 0);
        set_word(0, 32'h80011234);
        do_req(1, 0, 3'b101, 32'h80000002, 0, 0);
        do_req(0, 1, 3'b001, 32'h80000002, 32'h0000ABCD, 0);
        do_req(1, 0, 3'b010, 32'h80000001, 0, 0);
        do_req(1, 0, 3'b010, 32'h80000004, 0, 3);
        do_req(1, 1, 3'b010, 32'h80000008, 32'hDEADBEEF, 0);
        do_req(0, 0, 3'b111, 32'h80000005, 0, 0);
        do_req(0, 1, 3'b100, 32'h80000000, 32'h12345678, 0);
        do_req(1, 0, 3'b010, 32'h80000008, 0, 0);

        // reset while a load sits in RD_WAIT
        @(negedge clk);
        in_valid = 1; mem_ren_i = 1; mem_wen_i = 0; funct3_i = 3'b010; addr_i = 32'h80000010;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0; mem_ren_i = 0;
        rstn = 0; #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_sram_ren", sram_ren, 0);
        @(negedge clk);
        rstn = 1; #1;
        chk("mid_rst_release", in_ready, 1);
        do_req(0, 1, 3'b010, 32'h80000010, 32'hCAFEF00D, 0);
        do_req(1, 0, 3'b010, 32'h80000010, 0, 0);

        // random traffic
        for (int n = 0; n < 200; n++) begin
            logic r, w;
            logic [2:0] f;
            r = $urandom_range(0, 9) < 6;
            w = $urandom_range(0, 9) < 4;
            f = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 5)) : 3'($urandom);
            do_req(r, w, f, 32'h80000000 + $urandom_range(0, 63), $urandom, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
